// File: rtl/symbol_timing_controller.sv
// symbol_timing_controller
//   Closes the symbol-timing loop around a Gardner TED. A phase-accumulator NCO
//   runs at the input sample rate. Each carry-out arms a strobe, which fires as
//   `trigger` on the next valid sample. TED error words are taken through a
//   valid/ready handshake and run through a proportional-integral loop filter.
//   The filter output (`adj`) trims the NCO step.
//
//   Handshake: an error word is accepted on any cycle where ted_error_valid and
//   ted_error_ready are both high. ted_error_ready is high on every cycle after
//   the first clock edge out of reset. There is no back-pressure beyond that.
//
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     in_valid         one pulse per input sample
//     trigger          symbol strobe; only ever high together with in_valid
//     ted_error        signed TED error (ErrorLengthBits)
//     ted_error_valid  error qualifier
//     ted_error_ready  controller accepts error
//     adj              signed NCO step adjustment (debug view of filter output)
//     tracking         high in TRACK state (exposes FSM state)
//     locked           lock indicator
//
//   Optional feature macro: SYMBOL_TIMING_LOCK_DETECT_EN.
//   - Defined: a lock detector counts small TRACK-state errors.
//   - Undefined: locked is tied low.
//
//   Assumes ErrorLengthBits < AccumLengthBits + 1.
module symbol_timing_controller #(
  parameter int SamplesPerSymbol = 4,
  parameter int ErrorLengthBits  = 26,
  parameter int PhaseLengthBits  = 16,
  parameter int KpShift          = 8,
  parameter int KiShift          = 16,
  parameter int AccumLengthBits  = 32,
  parameter int AcquireSymbols   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              trigger,
  input  logic signed [ErrorLengthBits-1:0] ted_error,
  input  logic                              ted_error_valid,
  output logic                              ted_error_ready,
  output logic signed [PhaseLengthBits-1:0] adj,
  output logic                              tracking,
  output logic                              locked
);

  localparam int P  = PhaseLengthBits;
  localparam int A  = AccumLengthBits;
  localparam int E  = ErrorLengthBits;
  localparam int CW = $clog2(AcquireSymbols + 1);

  localparam int            STEP_I = (2 ** P) / SamplesPerSymbol;
  localparam int            HALF_I = STEP_I / 2;
  localparam logic [P:0]    STEP   = (P + 1)'(STEP_I);

  // Filter arithmetic is carried at A+1 bits, so the pre-saturation sums cannot wrap.
  localparam logic signed [A:0] INT_MAX = {2'b00, {(A - 1){1'b1}}};
  localparam logic signed [A:0] INT_MIN = {2'b11, {(A - 1){1'b0}}};
  localparam logic signed [A:0] ADJ_HI  = (A + 1)'(HALF_I - 1);
  localparam logic signed [A:0] ADJ_LO  = (A + 1)'(-HALF_I);

  typedef enum logic {
    S_ACQUIRE = 1'b0,
    S_TRACK   = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [P-1:0]          phase_q, phase_d;
  logic                  pend_q, pend_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [A-1:0]   integ_q, integ_d;
  logic signed [P-1:0]   adj_q, adj_d;
  logic                  ready_q, ready_d;

  logic [P:0]            inc;
  logic [P:0]            sum;
  logic                  trig;
  logic                  accept;
  logic signed [A:0]     e_ext;
  logic signed [A:0]     ki_term;
  logic signed [A:0]     kp_term;
  logic signed [A:0]     int_sum;
  logic signed [A:0]     int_sat;
  logic signed [A:0]     adj_sum;
  logic signed [A:0]     adj_clamped;

  always_comb begin
    // The clamp keeps step+adj within [step/2, 3*step/2), so it is always positive.
    // This also gives at most one carry per update.
    inc    = STEP + {adj_q[P-1], adj_q};
    sum    = {1'b0, phase_q} + inc;
    trig   = in_valid & pend_q;
    accept = ted_error_valid & ready_q;

    e_ext   = {{(A + 1 - E){ted_error[E-1]}}, ted_error};
    ki_term = e_ext >>> KiShift;
    kp_term = e_ext >>> KpShift;

    int_sum = {integ_q[A-1], integ_q} + ki_term;
    if (int_sum > INT_MAX)      int_sat = INT_MAX;
    else if (int_sum < INT_MIN) int_sat = INT_MIN;
    else                        int_sat = int_sum;

    adj_sum = kp_term + int_sat;
    if (adj_sum > ADJ_HI)      adj_clamped = ADJ_HI;
    else if (adj_sum < ADJ_LO) adj_clamped = ADJ_LO;
    else                       adj_clamped = adj_sum;

    state_d = state_q;
    phase_d = phase_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    integ_d = integ_q;
    adj_d   = adj_q;
    ready_d = 1'b1;

    // A trigger always consumes the pending strobe, because trig implies in_valid.
    // The only thing that can re-arm the strobe is the carry from this same update.
    if (in_valid) begin
      phase_d = sum[P-1:0];
      pend_d  = sum[P];
    end

    case (state_q)
      S_ACQUIRE: begin
        // Errors accepted here are dropped; adj stays at zero.
        if (trig) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(AcquireSymbols - 1)) state_d = S_TRACK;
        end
      end
      S_TRACK: begin
        if (accept) begin
          integ_d = A'(int_sat);
          adj_d   = P'(adj_clamped);
        end
      end
      default: state_d = S_ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_ACQUIRE;
      phase_q <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      integ_q <= '0;
      adj_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      integ_q <= integ_d;
      adj_q   <= adj_d;
      ready_q <= ready_d;
    end
  end

  assign trigger         = trig;
  assign adj             = adj_q;
  assign tracking        = (state_q == S_TRACK);
  assign ted_error_ready = ready_q;

`ifdef SYMBOL_TIMING_LOCK_DETECT_EN
  // "Small" means |ted_error| < 2^(E-8). Any larger accepted error breaks lock at once.
  localparam logic signed [A:0] LOCK_LIM = (A + 1)'(64'sd1 <<< (E - 8));
  localparam logic signed [A:0] LOCK_NEG = -LOCK_LIM;

  logic [6:0] lock_cnt_q, lock_cnt_d;
  logic       locked_q, locked_d;
  logic       small_err;

  always_comb begin
    small_err  = (e_ext < LOCK_LIM) && (e_ext > LOCK_NEG);
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if ((state_q == S_TRACK) && accept) begin
      if (small_err) begin
        lock_cnt_d = (lock_cnt_q >= 7'd64) ? 7'd64 : lock_cnt_q + 7'd1;
        locked_d   = (lock_cnt_d >= 7'd32);
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_symbol_timing_controller.sv
module tb_symbol_timing_controller;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               trigger;
  logic [25:0]        ted_error;
  logic               ted_error_valid;
  logic               ted_error_ready;
  logic signed [15:0] adj;
  logic               tracking;
  logic               locked;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state, held at the level of the loop equations.
  bit     m_ok = 1'b0;
  int     m_ph, m_pend, m_adj, m_cnt, m_track, m_rdy, m_lc, m_locked;
  longint m_int;

  // Valid-sample index (1-based since reset) of every observed trigger.
  int vcount;
  int trig_q[$];

  symbol_timing_controller dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .trigger(trigger),
    .ted_error(ted_error), .ted_error_valid(ted_error_valid),
    .ted_error_ready(ted_error_ready), .adj(adj), .tracking(tracking),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one clock cycle of inputs and compare the outputs against the model.
  // Then advance the model across the coming posedge.
  task automatic cycle(input bit r, input bit v, input bit ev, input int e);
    int     trig, acc, t_old;
    int     s, a;
    longint li;
    @(negedge clk);
    rst = r; in_valid = v; ted_error_valid = ev; ted_error = e[25:0];
    #1;
    trig = (v && m_pend) ? 1 : 0;
    if (m_ok) begin
      chk("trigger",  trigger,         trig);
      chk("adj",      adj,             m_adj);
      chk("tracking", tracking,        m_track);
      chk("ready",    ted_error_ready, m_rdy);
      chk("locked",   locked,          m_locked);
    end
    if (r) begin
      vcount = 0;
      trig_q.delete();
    end else if (v) begin
      vcount++;
      if (trigger === 1'b1) trig_q.push_back(vcount);
    end

    if (r) begin
      m_ok = 1'b1;
      m_ph = 0; m_pend = 0; m_adj = 0; m_cnt = 0; m_track = 0;
      m_rdy = 0; m_lc = 0; m_locked = 0; m_int = 0;
    end else if (m_ok) begin
      acc   = (ev && m_rdy) ? 1 : 0;
      t_old = m_track;
      if (v) begin
        s      = m_ph + 16384 + m_adj;
        m_pend = (s >= 65536) ? 1 : 0;
        m_ph   = s % 65536;
      end
      if (!t_old) begin
        if (trig) begin
          m_cnt++;
          if (m_cnt == 16) m_track = 1;
        end
      end else if (acc) begin
        li = m_int + longint'(e >>> 16);
        if (li > 64'sd2147483647)  li = 64'sd2147483647;
        if (li < -64'sd2147483648) li = -64'sd2147483648;
        m_int = li;
        li = longint'(e >>> 8) + m_int;
        if (li > 8191)  li = 8191;
        if (li < -8192) li = -8192;
        a = int'(li);
        m_adj = a;
      end
`ifdef SYMBOL_TIMING_LOCK_DETECT_EN
      if (t_old && acc) begin
        if (e < (1 << 18) && e > -(1 << 18)) begin
          if (m_lc < 64) m_lc++;
          m_locked = (m_lc >= 32) ? 1 : 0;
        end else begin
          m_lc = 0;
          m_locked = 0;
        end
      end
`endif
      m_rdy = 1;
    end
  endtask

  initial begin
    int d;
    rst = 1'b1; in_valid = 1'b0; ted_error_valid = 1'b0; ted_error = '0;

    // Reset state.
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("rst_trigger", trigger, 0);
    chk("rst_adj", adj, 0);
    chk("rst_tracking", tracking, 0);
    chk("rst_ready", ted_error_ready, 0);
    chk("rst_locked", locked, 0);

    // 1: continuous valid, no errors.
    repeat (70) cycle(0, 1, 0, 0);
    chk("t1_first", trig_q[0], 5);
    chk("t1_second", trig_q[1], 9);
    chk("t1_third", trig_q[2], 13);
    chk("t1_16th", trig_q[15], 65);
    chk("t1_tracking", tracking, 1);
    chk("t1_adj", adj, 0);

    // 2: in_valid toggling.
    cycle(1, 0, 0, 0);
    repeat (20) begin
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
    end
    chk("t2_first", trig_q[0], 5);
    chk("t2_second", trig_q[1], 9);
    chk("t2_fourth", trig_q[3], 17);
    chk("t2_count", trig_q.size(), 4);

    // 3: errors during ACQUIRE are ignored.
    cycle(1, 0, 0, 0);
    repeat (65) cycle(0, 1, 1, 1000000);
    chk("t3_count", trig_q.size(), 16);
    chk("t3_16th", trig_q[15], 65);
    chk("t3_adj", adj, 0);
    chk("t3_ready", ted_error_ready, 1);
    chk("t3_tracking", tracking, 0);

    // 4: large positive error, then large negative error.
    repeat (20) cycle(0, 1, 1, 1 << 24);
    chk("t4_adj_pos", adj, 8191);
    d = trig_q[trig_q.size()-1] - trig_q[trig_q.size()-2];
    chk("t4_spacing_pos", (d == 2 || d == 3) ? 1 : 0, 1);
    repeat (40) cycle(0, 1, 1, -(1 << 24));
    chk("t4_adj_neg", adj, -8192);
    d = trig_q[trig_q.size()-1] - trig_q[trig_q.size()-2];
    chk("t4_spacing_neg", d, 8);

    // 5: reset mid-TRACK.
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t5_adj", adj, 0);
    chk("t5_tracking", tracking, 0);
    chk("t5_trigger", trigger, 0);
    repeat (6) cycle(0, 1, 0, 0);
    chk("t5_first", trig_q[0], 5);
    chk("t5_count", trig_q.size(), 1);

    // 6: lock detector.
    repeat (60) cycle(0, 1, 0, 0);
    chk("t6_tracking", tracking, 1);
    repeat (32) cycle(0, 1, 1, 100);
    chk("t6_locked_31", locked, 0);
    cycle(0, 1, 0, 0);
`ifdef SYMBOL_TIMING_LOCK_DETECT_EN
    chk("t6_locked_32", locked, 1);
`else
    chk("t6_locked_32", locked, 0);
`endif
    cycle(0, 1, 1, 1 << 20);
    cycle(0, 1, 0, 0);
    chk("t6_unlock", locked, 0);
    chk("t6_adj", adj, 4112);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
